// File: rtl/reflex_game_if.sv
// Game-slot interface between the menu (master) and a game (slave):
// enable and board inputs go to the game; the game returns the display and its highscore.
interface reflex_game_if;
  logic        en;
  logic [17:0] SW;
  logic [3:0]  KEY;
  logic [17:0] LEDR;
  logic [7:0]  LEDG;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [10:0] highscore;

  modport master (
    output en, SW, KEY,
    input  LEDR, LEDG, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7, highscore
  );

  modport slave (
    input  en, SW, KEY,
    output LEDR, LEDG, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7, highscore
  );
endinterface

// File: rtl/reflex_game.sv
// Reaction-time game on the menu game slot: random wait, GO, ms timer, score and highscore.
// Optional FOUL state for early presses is built when REFLEX_FOUL_EN is defined.
module reflex_game #(
  parameter int MS_CYCLES    = 50000,
  parameter int DELAY_MIN_MS = 1000,
  parameter int DELAY_BITS   = 10
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  reflex_game_if.slave slot
);

  localparam int PW = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam int DW = $clog2(DELAY_MIN_MS + (1 << DELAY_BITS)) + 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_I     = 7'b1111001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAITREL,
    S_ARMED,
    S_GO,
    S_RESULT
`ifdef REFLEX_FOUL_EN
    , S_FOUL
`endif
  } state_t;

  state_t          state, state_nxt;
  logic            key_meta, key_sync, key_sync_q, press;
  logic            en_q, en_rise;
  logic [15:0]     lfsr;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [DW-1:0]   delay_cnt;
  logic [15:0]     ms_bcd;
  logic            ms_sat;
  logic [6:0]      ms_coarse, score, hs_q;
  logic            score_pend;
  logic [7:0][6:0] hex_d, hex_q;
  logic [17:0]     ledr_d, ledr_q;
  logic [7:0]      ledg_d, ledg_q;
  logic            unused_inputs;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Synchroniser resets to "released" so reset exit never looks like a press.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_meta   <= 1'b1;
      key_sync   <= 1'b1;
      key_sync_q <= 1'b1;
      en_q       <= 1'b0;
      lfsr       <= 16'hACE1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      key_meta   <= slot.KEY[0];
      key_sync   <= key_meta;
      key_sync_q <= key_sync;
      en_q       <= slot.en;
      lfsr       <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign press         = key_sync_q & ~key_sync;
  assign en_rise       = slot.en & ~en_q;
  assign tick          = (presc == PW'(MS_CYCLES - 1));
  assign ms_sat        = (ms_bcd == 16'h9999);
  assign ms_coarse     = 7'(ms_bcd[11:8]) * 7'd10 + 7'(ms_bcd[7:4]);
  assign score         = (ms_bcd[15:12] == 4'd0) ? 7'd99 - ms_coarse : 7'd0;
  assign unused_inputs = ^{slot.SW, slot.KEY[3:1]};

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE:    if (en_rise) state_nxt = S_WAITREL;
      S_WAITREL: if (key_sync) state_nxt = S_ARMED;
      S_ARMED: begin
        if (tick && delay_cnt == DW'(1)) state_nxt = S_GO;
`ifdef REFLEX_FOUL_EN
        if (press) state_nxt = S_FOUL;
`endif
      end
      S_GO:      if (press || ms_sat) state_nxt = S_RESULT;
      S_RESULT:  if (press) state_nxt = S_ARMED;
`ifdef REFLEX_FOUL_EN
      S_FOUL:    if (press) state_nxt = S_ARMED;
`endif
      default:   state_nxt = S_IDLE;
    endcase
    // Losing the slot overrides everything, including a simultaneous press.
    if (!slot.en) state_nxt = S_IDLE;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      presc      <= '0;
      delay_cnt  <= '0;
      ms_bcd     <= '0;
      score_pend <= 1'b0;
      hs_q       <= '0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state || state_nxt == S_IDLE || tick) presc <= '0;
      else                                                   presc <= presc + PW'(1);

      if (state_nxt == S_ARMED && state != S_ARMED)
        delay_cnt <= DW'(DELAY_MIN_MS) + DW'(lfsr[DELAY_BITS-1:0]);
      else if (state == S_ARMED && tick)
        delay_cnt <= delay_cnt - DW'(1);

      if (state_nxt == S_IDLE || (state_nxt == S_GO && state != S_GO))
        ms_bcd <= '0;
      else if (state == S_GO && tick && !ms_sat)
        ms_bcd <= bcd_inc(ms_bcd);

      // Score is taken one cycle after RESULT entry, from the frozen count.
      score_pend <= (state_nxt == S_RESULT) && (state != S_RESULT);
      if (score_pend && score > hs_q) hs_q <= score;
    end
  end

  always_comb begin
    ledr_d = '0;
    ledg_d = '0;
    hex_d  = {8{SEG_BLANK}};
    case (state)
      S_ARMED: begin
        ledr_d     = '1;
        hex_d[3:0] = {4{SEG_DASH}};
      end
      S_GO: begin
        ledg_d     = 8'hFF;
        hex_d[3:0] = {seg7(ms_bcd[15:12]), seg7(ms_bcd[11:8]),
                      seg7(ms_bcd[7:4]),   seg7(ms_bcd[3:0])};
      end
      S_RESULT: begin
        hex_d[3:0] = {seg7(ms_bcd[15:12]), seg7(ms_bcd[11:8]),
                      seg7(ms_bcd[7:4]),   seg7(ms_bcd[3:0])};
        hex_d[4]   = seg7(4'(score % 7'd10));
        hex_d[5]   = seg7(4'(score / 7'd10));
        hex_d[6]   = SEG_I;
        hex_d[7]   = SEG_H;
      end
`ifdef REFLEX_FOUL_EN
      S_FOUL: hex_d[3:0] = {7'b0001110, 7'b1000000, 7'b1000001, 7'b1000111};
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      hex_q  <= {8{SEG_BLANK}};
      ledr_q <= '0;
      ledg_q <= '0;
    end else begin
      hex_q  <= hex_d;
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
    end
  end

  assign slot.HEX0      = hex_q[0];
  assign slot.HEX1      = hex_q[1];
  assign slot.HEX2      = hex_q[2];
  assign slot.HEX3      = hex_q[3];
  assign slot.HEX4      = hex_q[4];
  assign slot.HEX5      = hex_q[5];
  assign slot.HEX6      = hex_q[6];
  assign slot.HEX7      = hex_q[7];
  assign slot.LEDR      = ledr_q;
  assign slot.LEDG      = ledg_q;
  assign slot.highscore = {4'd0, hs_q};

endmodule

// File: tb/tb_reflex_game.sv
// Directed bench for reflex_game: reset, selection release, three scored rounds,
// early press in ARMED (FOUL when REFLEX_FOUL_EN is defined), en drop and reset.
module tb_reflex_game;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
  localparam logic [6:0] SH = 7'b0001001, SI = 7'b1111001, SD = 7'b0111111;
  localparam logic [27:0] BLANK4 = 28'hFFFFFFF;

  reflex_game_if slot ();

  reflex_game #(
    .MS_CYCLES   (4),
    .DELAY_MIN_MS(5),
    .DELAY_BITS  (2)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .slot    (slot.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_go(input string tag);
    int n = 0;
    while (slot.LEDG !== 8'hFF && n < 200) begin
      step(1);
      n++;
    end
    check(tag, 32'(slot.LEDG), 32'hFF);
  endtask

  function automatic logic [27:0] hex_lo();
    return {slot.HEX3, slot.HEX2, slot.HEX1, slot.HEX0};
  endfunction

  function automatic logic [27:0] hex_hi();
    return {slot.HEX7, slot.HEX6, slot.HEX5, slot.HEX4};
  endfunction

  // Press from RESULT (or FOUL) back into ARMED; display is checked one cycle after entry.
  task automatic rearm(input string tag);
    step(3);
    slot.KEY = 4'hE;
    step(4);
    check(tag, 32'(slot.LEDR), 32'h3FFFF);
    slot.KEY = 4'hF;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn    = 1'b0;
    slot.en   = 1'b0;
    slot.SW   = '0;
    slot.KEY  = 4'hF;
    #23 resetn = 1'b1;
    step(100);
    check("reset_hex_lo", 32'(hex_lo()), 32'(BLANK4));
    check("reset_hex_hi", 32'(hex_hi()), 32'(BLANK4));
    check("reset_ledr", 32'(slot.LEDR), 32'h0);
    check("reset_ledg", 32'(slot.LEDG), 32'h0);
    check("reset_hs", 32'(slot.highscore), 32'd0);

    // Selection press is already down when the menu raises en.
    slot.KEY = 4'hE;
    step(3);
    slot.en = 1'b1;
    step(20);
    check("waitrel_ledr", 32'(slot.LEDR), 32'h0);
    check("waitrel_hex", 32'(hex_lo()), 32'(BLANK4));
    slot.KEY = 4'hF;
    step(4);
    check("armed_ledr", 32'(slot.LEDR), 32'h3FFFF);
    check("armed_dash", 32'(hex_lo()), 32'({SD, SD, SD, SD}));

    // Round 1: RESULT entry lands 494 cycles after GO entry -> 123 ms.
    wait_go("go1");
    check("go1_ledr", 32'(slot.LEDR), 32'h0);
    step(490);
    slot.KEY = 4'hE;
    step(3);
    check("r1_hs_before", 32'(slot.highscore), 32'd0);
    check("r1_ledg_before", 32'(slot.LEDG), 32'hFF);
    step(1);
    check("r1_ms", 32'(hex_lo()), 32'({S0, S1, S2, S3}));
    check("r1_score", 32'(hex_hi()), 32'({SH, SI, S8, S7}));
    check("r1_hs", 32'(slot.highscore), 32'd87);
    check("r1_ledg", 32'(slot.LEDG), 32'h0);
    slot.KEY = 4'hF;

    // Round 2: 1802 cycles after GO entry -> 450 ms, score 54.
    rearm("armed2");
    wait_go("go2");
    step(1798);
    slot.KEY = 4'hE;
    step(4);
    check("r2_ms", 32'(hex_lo()), 32'({S0, S4, S5, S0}));
    check("r2_score", 32'(hex_hi()), 32'({SH, SI, S5, S4}));
    check("r2_hs", 32'(slot.highscore), 32'd87);
    slot.KEY = 4'hF;

    // Round 3: early press in ARMED, then GO runs to saturation.
    rearm("armed3");
    step(2);
    slot.KEY = 4'hE;
    step(4);
`ifdef REFLEX_FOUL_EN
    check("foul_hex", 32'(hex_lo()), 32'({7'b0001110, 7'b1000000, 7'b1000001, 7'b1000111}));
    check("foul_hs", 32'(slot.highscore), 32'd87);
    slot.KEY = 4'hF;
    rearm("foul_exit");
`else
    check("early_dash", 32'(hex_lo()), 32'({SD, SD, SD, SD}));
    check("early_ledr", 32'(slot.LEDR), 32'h3FFFF);
    slot.KEY = 4'hF;
`endif
    wait_go("go3");
    step(39997);
    check("r3_ms", 32'(hex_lo()), 32'({S9, S9, S9, S9}));
    check("r3_score", 32'(hex_hi()), 32'({SH, SI, S0, S0}));
    check("r3_ledg", 32'(slot.LEDG), 32'h0);
    step(1);
    check("r3_hs", 32'(slot.highscore), 32'd87);

    // Round 4: en drops mid-GO.
    rearm("armed4");
    wait_go("go4");
    step(50);
    slot.en = 1'b0;
    step(1);
    check("endrop_ledg_lag", 32'(slot.LEDG), 32'hFF);
    step(1);
    check("endrop_hex_lo", 32'(hex_lo()), 32'(BLANK4));
    check("endrop_hex_hi", 32'(hex_hi()), 32'(BLANK4));
    check("endrop_ledg", 32'(slot.LEDG), 32'h0);
    check("endrop_hs", 32'(slot.highscore), 32'd87);

    resetn = 1'b0;
    #2;
    check("rst_hs_async", 32'(slot.highscore), 32'd0);
    resetn = 1'b1;
    step(2);
    check("rst_hs", 32'(slot.highscore), 32'd0);
    check("rst_hex_lo", 32'(hex_lo()), 32'(BLANK4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
